// File: rtl/e203_exu_wbck_arb_if.sv
// ----------------------------------------------------------------------------
// e203_exu_wbck_arb_if
// Bundle between the EXU write-back producers and the write-back arbiter.
//
// Producer side (inputs to the arbiter):
//   src_valid  [NSRC]          per-source write-back request
//   src_wdat   [NSRC*XLEN]     flattened data, source i at [i*XLEN +: XLEN]
//   src_rdidx  [NSRC*RFIDX_W]  flattened destination index
//   src_rdfpu  [NSRC]          destination is the FP regfile
// Arbiter side (outputs of the arbiter):
//   src_ready  [NSRC]          one-hot or zero grant
//   rf_wbck_o_ena, fp_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx
//   wbck_busy                  a regfile write is presented this cycle
//   dbg_cnt    [NSRC*CNT_W]    flattened starvation counters, for observation
//
// Handshake: a source raises src_valid and holds valid/data stable; the
// transfer completes in the cycle where src_valid[i] & src_ready[i] is 1.
//
// Modports: slave = the arbiter, master = the producers / environment.
// ----------------------------------------------------------------------------
interface e203_exu_wbck_arb_if #(
    parameter int NSRC    = 2,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int CNT_W   = 4
);
    logic [NSRC-1:0]         src_valid;
    logic [NSRC-1:0]         src_ready;
    logic [NSRC*XLEN-1:0]    src_wdat;
    logic [NSRC*RFIDX_W-1:0] src_rdidx;
    logic [NSRC-1:0]         src_rdfpu;
    logic                    rf_wbck_o_ena;
    logic                    fp_wbck_o_ena;
    logic [XLEN-1:0]         rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]      rf_wbck_o_rdidx;
    logic                    wbck_busy;
    logic [NSRC*CNT_W-1:0]   dbg_cnt;

    modport slave (
        input  src_valid, src_wdat, src_rdidx, src_rdfpu,
        output src_ready, rf_wbck_o_ena, fp_wbck_o_ena,
               rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_busy, dbg_cnt
    );

    modport master (
        output src_valid, src_wdat, src_rdidx, src_rdfpu,
        input  src_ready, rf_wbck_o_ena, fp_wbck_o_ena,
               rf_wbck_o_wdat, rf_wbck_o_rdidx, wbck_busy, dbg_cnt
    );
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// ----------------------------------------------------------------------------
// e203_exu_wbck_arb
// N-source write-back arbiter in front of the single regfile write port.
// Fixed priority (highest index wins) with per-source starvation counters:
// a source valid but not granted for STARVE_MAX cycles is promoted above all
// others; among promoted sources the lowest index wins.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   wb     e203_exu_wbck_arb_if.slave (source requests in, grant and
//          regfile write port out, starvation counters on dbg_cnt)
//
// Optional feature macro: E203_WBCK_ARB_BYPASS_EN
//   undefined (default): registered output, grant in T -> write in T+1
//   defined:             output register removed, write in the grant cycle
// ----------------------------------------------------------------------------
module e203_exu_wbck_arb #(
    parameter int NSRC       = 2,
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    e203_exu_wbck_arb_if.slave   wb
);
    localparam int SEL_W = $clog2(NSRC);

    logic [CNT_W-1:0]   cnt [NSRC];
    logic [NSRC-1:0]    starved;
    logic [SEL_W-1:0]   sel;
    logic               any_grant;
    logic [NSRC-1:0]    grant;
    logic [XLEN-1:0]    g_wdat;
    logic [RFIDX_W-1:0] g_rdidx;
    logic               g_fpu;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            starved[i] = wb.src_valid[i] & (cnt[i] >= CNT_W'(STARVE_MAX));
        end
    end

    // Ascending scan leaves the highest valid index; if anything is starved,
    // a descending scan over starved sources overrides it with the lowest.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (wb.src_valid[i]) sel = SEL_W'(i);
        end
        if (|starved) begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (starved[i]) sel = SEL_W'(i);
            end
        end
    end

    // No grant is issued while reset is held, even with requests pending.
    assign any_grant    = rst_n & (|wb.src_valid);
    assign grant        = any_grant ? (NSRC'(1) << sel) : '0;
    assign wb.src_ready = grant;

    assign g_wdat  = wb.src_wdat[sel*XLEN +: XLEN];
    assign g_rdidx = wb.src_rdidx[sel*RFIDX_W +: RFIDX_W];
    assign g_fpu   = wb.src_rdfpu[sel];

    // Counters clear on grant or when the request drops, else saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (!wb.src_valid[i] || grant[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_W'(STARVE_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_dbg
        assign wb.dbg_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
    end

`ifdef E203_WBCK_ARB_BYPASS_EN
    assign wb.rf_wbck_o_ena   = any_grant & ~g_fpu;
    assign wb.fp_wbck_o_ena   = any_grant & g_fpu;
    assign wb.rf_wbck_o_wdat  = g_wdat;
    assign wb.rf_wbck_o_rdidx = g_rdidx;
`else
    logic               rf_ena_q;
    logic               fp_ena_q;
    logic [XLEN-1:0]    wdat_q;
    logic [RFIDX_W-1:0] rdidx_q;

    // Data/index hold their last value when idle; only the enables clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_ena_q <= 1'b0;
            fp_ena_q <= 1'b0;
            wdat_q   <= '0;
            rdidx_q  <= '0;
        end else if (any_grant) begin
            rf_ena_q <= ~g_fpu;
            fp_ena_q <= g_fpu;
            wdat_q   <= g_wdat;
            rdidx_q  <= g_rdidx;
        end else begin
            rf_ena_q <= 1'b0;
            fp_ena_q <= 1'b0;
        end
    end

    assign wb.rf_wbck_o_ena   = rf_ena_q;
    assign wb.fp_wbck_o_ena   = fp_ena_q;
    assign wb.rf_wbck_o_wdat  = wdat_q;
    assign wb.rf_wbck_o_rdidx = rdidx_q;
`endif

    assign wb.wbck_busy = wb.rf_wbck_o_ena | wb.fp_wbck_o_ena;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// ----------------------------------------------------------------------------
// tb_e203_exu_wbck_arb
// Directed bench for e203_exu_wbck_arb: a 2-source instance (STARVE_MAX=4)
// and a 4-source instance (STARVE_MAX=2). Inputs are driven 1 time unit after
// the rising edge; outputs are sampled 1-4 units after that.
// ----------------------------------------------------------------------------
module tb_e203_exu_wbck_arb;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    e203_exu_wbck_arb_if #(.NSRC(2), .XLEN(32), .RFIDX_W(5), .CNT_W(4)) ifa ();
    e203_exu_wbck_arb_if #(.NSRC(4), .XLEN(32), .RFIDX_W(5), .CNT_W(4)) ifb ();

    e203_exu_wbck_arb #(.NSRC(2), .XLEN(32), .RFIDX_W(5), .STARVE_MAX(4), .CNT_W(4))
        dut_a (.clk(clk), .rst_n(rst_n), .wb(ifa.slave));
    e203_exu_wbck_arb #(.NSRC(4), .XLEN(32), .RFIDX_W(5), .STARVE_MAX(2), .CNT_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .wb(ifb.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard check
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // expected grant sequences
    int exp3_src [6];
    int exp3_cnt [6];
    int exp5_src [8];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp3_src = '{1, 1, 1, 1, 0, 1};
        exp3_cnt = '{1, 2, 3, 4, 0, 1};
        exp5_src = '{3, 3, 0, 1, 2, 0, 1, 2};

        // ---- 1. reset with both sources requesting
        rst_n         = 1'b0;
        ifa.src_valid = 2'b11;
        ifa.src_wdat  = {32'h1111_0001, 32'h0000_0000};
        ifa.src_rdidx = {5'd9, 5'd7};
        ifa.src_rdfpu = 2'b00;
        ifb.src_valid = 4'b0000;
        ifb.src_rdfpu = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ifb.src_wdat[i*32 +: 32] = 32'hA0 + 32'(i);
            ifb.src_rdidx[i*5 +: 5]  = 5'(10 + i);
        end
        #2;
        check_val("rst_ready", 64'(ifa.src_ready), 64'h0);
        check_val("rst_rf_ena", 64'(ifa.rf_wbck_o_ena), 64'h0);
        check_val("rst_fp_ena", 64'(ifa.fp_wbck_o_ena), 64'h0);
        check_val("rst_wdat", 64'(ifa.rf_wbck_o_wdat), 64'h0);
        check_val("rst_rdidx", 64'(ifa.rf_wbck_o_rdidx), 64'h0);
        check_val("rst_busy", 64'(ifa.wbck_busy), 64'h0);
        check_val("rst_cnt", 64'(ifa.dbg_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_ready", 64'(ifa.src_ready), 64'h2);
        tick();
        check_val("post_rst_rf_ena", 64'(ifa.rf_wbck_o_ena), 64'h1);
        check_val("post_rst_wdat", 64'(ifa.rf_wbck_o_wdat), 64'h1111_0001);
        check_val("post_rst_rdidx", 64'(ifa.rf_wbck_o_rdidx), 64'd9);
        ifa.src_valid = 2'b00;
        tick();

        // ---- 2. single source, low priority
        ifa.src_valid = 2'b01;
        ifa.src_wdat[31:0] = 32'hDEAD_BEEF;
        ifa.src_rdidx[4:0] = 5'd7;
        #1;
        check_val("single_ready", 64'(ifa.src_ready), 64'h1);
        tick();
        check_val("single_rf_ena", 64'(ifa.rf_wbck_o_ena), 64'h1);
        check_val("single_fp_ena", 64'(ifa.fp_wbck_o_ena), 64'h0);
        check_val("single_wdat", 64'(ifa.rf_wbck_o_wdat), 64'hDEAD_BEEF);
        check_val("single_rdidx", 64'(ifa.rf_wbck_o_rdidx), 64'd7);
        check_val("single_busy", 64'(ifa.wbck_busy), 64'h1);
        ifa.src_valid = 2'b00;
        #1;
        check_val("idle_ready", 64'(ifa.src_ready), 64'h0);
        tick();
        check_val("idle_rf_ena", 64'(ifa.rf_wbck_o_ena), 64'h0);
        check_val("idle_busy", 64'(ifa.wbck_busy), 64'h0);
        check_val("idle_wdat_hold", 64'(ifa.rf_wbck_o_wdat), 64'hDEAD_BEEF);

        // ---- 3. starvation promotion, STARVE_MAX=4
        ifa.src_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val($sformatf("starve_ready_%0d", k), 64'(ifa.src_ready),
                      64'(1) << exp3_src[k]);
            tick();
            check_val($sformatf("starve_rdidx_%0d", k), 64'(ifa.rf_wbck_o_rdidx),
                      (exp3_src[k] == 1) ? 64'd9 : 64'd7);
            check_val($sformatf("starve_cnt0_%0d", k), 64'(ifa.dbg_cnt[3:0]),
                      64'(exp3_cnt[k]));
        end
        ifa.src_valid = 2'b00;
        tick();

        // ---- 4. FP routing
        ifa.src_valid = 2'b10;
        ifa.src_rdfpu = 2'b10;
        ifa.src_rdidx[9:5] = 5'd3;
        ifa.src_wdat[63:32] = 32'h3F80_0000;
        #1;
        check_val("fp_ready", 64'(ifa.src_ready), 64'h2);
        tick();
        check_val("fp_fp_ena", 64'(ifa.fp_wbck_o_ena), 64'h1);
        check_val("fp_rf_ena", 64'(ifa.rf_wbck_o_ena), 64'h0);
        check_val("fp_rdidx", 64'(ifa.rf_wbck_o_rdidx), 64'd3);
        check_val("fp_wdat", 64'(ifa.rf_wbck_o_wdat), 64'h3F80_0000);
        check_val("fp_busy", 64'(ifa.wbck_busy), 64'h1);
        ifa.src_valid = 2'b00;
        ifa.src_rdfpu = 2'b00;
        tick();

        // ---- 5. multi-starve, NSRC=4, STARVE_MAX=2
        ifb.src_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val($sformatf("multi_ready_%0d", k), 64'(ifb.src_ready),
                      64'(1) << exp5_src[k]);
            tick();
            check_val($sformatf("multi_ena_%0d", k), 64'(ifb.rf_wbck_o_ena), 64'h1);
            check_val($sformatf("multi_rdidx_%0d", k), 64'(ifb.rf_wbck_o_rdidx),
                      64'(10 + exp5_src[k]));
            check_val($sformatf("multi_wdat_%0d", k), 64'(ifb.rf_wbck_o_wdat),
                      64'(32'hA0 + 32'(exp5_src[k])));
        end
        ifb.src_valid = 4'b0000;
        tick();

        // ---- 6. asynchronous reset mid-stream
        ifa.src_valid = 2'b11;
        tick();
        tick();
        check_val("midrst_pre_ena", 64'(ifa.rf_wbck_o_ena), 64'h1);
        check_val("midrst_pre_cnt0", 64'(ifa.dbg_cnt[3:0]), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ena", 64'(ifa.rf_wbck_o_ena), 64'h0);
        check_val("midrst_busy", 64'(ifa.wbck_busy), 64'h0);
        check_val("midrst_ready", 64'(ifa.src_ready), 64'h0);
        ifa.src_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("midrst_cnt", 64'(ifa.dbg_cnt), 64'h0);
        check_val("midrst_wdat", 64'(ifa.rf_wbck_o_wdat), 64'h0);
        tick();
        check_val("midrst_idle_ena", 64'(ifa.rf_wbck_o_ena), 64'h0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
